// File: rtl/ebpf_div_pkg.sv
// rtl/ebpf_div_pkg.sv - shared types and constants for the eBPF iterative divider
package ebpf_div_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic is_mod;
        logic is_32;
        logic is_signed;
    } op_t;

    // ALU32 ops see only the low word; the upper word reads as zero
    function automatic logic [XLEN-1:0] width_mask(input logic [XLEN-1:0] v, input logic is_32);
        return is_32 ? {32'd0, v[31:0]} : v;
    endfunction

endpackage

// File: rtl/ebpf_div_seq_if.sv
// rtl/ebpf_div_seq_if.sv - request/response handshake bundle for ebpf_div_seq
interface ebpf_div_seq_if;
    import ebpf_div_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            req_is_mod;
    logic            req_is_32;
    logic            req_is_signed;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_y;
    logic            busy;

    modport master (
        output req_valid, req_a, req_b, req_is_mod, req_is_32, req_is_signed, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_is_mod, req_is_32, req_is_signed, rsp_ready,
        output req_ready, rsp_valid, rsp_y, busy
    );

endinterface

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division step on {rem, quo}
module div_restore_step
    import ebpf_div_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    // One extra bit: a 64-bit divisor can leave a shifted remainder of 2^64 or more
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    assign rem_sh = {rem, quo[XLEN-1]};
    assign diff   = rem_sh - {1'b0, divisor};

    always_comb begin
        rem_next = rem_sh[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], 1'b0};
        if (rem_sh >= {1'b0, divisor}) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ebpf_div_seq.sv
// rtl/ebpf_div_seq.sv - eBPF DIV/MOD sequencer, one quotient bit per cycle; EBPF_DIV_SIGNED_EN adds SDIV/SMOD
module ebpf_div_seq
    import ebpf_div_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    ebpf_div_seq_if.slave bus
);

    state_t          state, state_nxt;
    op_t             op_q;
    logic [5:0]      cnt;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q, y_q;
    logic            neg_quo_q, neg_rem_q;

    logic            accept, last, sgn, a_neg, b_neg, b_zero;
    logic [XLEN-1:0] a_w, b_w, a_abs, b_abs;
    logic [XLEN-1:0] rem_nx, quo_nx, quo_fix, rem_fix, result;

`ifdef EBPF_DIV_SIGNED_EN
    assign sgn = bus.req_is_signed;
`else
    logic unused_is_signed;
    assign unused_is_signed = bus.req_is_signed;
    assign sgn = 1'b0;
`endif

    assign accept = bus.req_valid && (state == IDLE);
    assign a_w    = width_mask(bus.req_a, bus.req_is_32);
    assign b_w    = width_mask(bus.req_b, bus.req_is_32);
    assign b_zero = (b_w == '0);
    assign a_neg  = sgn && (bus.req_is_32 ? a_w[31] : a_w[XLEN-1]);
    assign b_neg  = sgn && (bus.req_is_32 ? b_w[31] : b_w[XLEN-1]);
    // MIN_INT stays MIN_INT here; as an unsigned magnitude that is exactly right
    assign a_abs  = a_neg ? width_mask(-a_w, bus.req_is_32) : a_w;
    assign b_abs  = b_neg ? width_mask(-b_w, bus.req_is_32) : b_w;

    assign last   = (cnt == (op_q.is_32 ? 6'd31 : 6'd63));

    div_restore_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    assign quo_fix = neg_quo_q ? width_mask(-quo_nx, op_q.is_32) : width_mask(quo_nx, op_q.is_32);
    assign rem_fix = neg_rem_q ? width_mask(-rem_nx, op_q.is_32) : width_mask(rem_nx, op_q.is_32);
    assign result  = op_q.is_mod ? rem_fix : quo_fix;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = b_zero ? DONE : RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            y_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q      <= '{is_mod: bus.req_is_mod, is_32: bus.req_is_32, is_signed: sgn};
                    cnt       <= '0;
                    rem_q     <= '0;
                    // ALU32 dividend sits in the top word so the shift-out order matches ALU64
                    quo_q     <= bus.req_is_32 ? {a_abs[31:0], 32'd0} : a_abs;
                    dvs_q     <= b_abs;
                    neg_quo_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    if (b_zero) y_q <= bus.req_is_mod ? a_w : '0;
                end
                RUN: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    if (last) y_q <= result;
                    else      cnt <= cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_y     = y_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_ebpf_div_seq.sv
// tb/tb_ebpf_div_seq.sv - randomized and directed self-checking bench for ebpf_div_seq
module tb_ebpf_div_seq;
    import ebpf_div_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ebpf_div_seq_if ifc ();

    ebpf_div_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_y(input logic [63:0] a, input logic [63:0] b,
                                          input logic is_mod, input logic is_32, input logic sgn);
        logic [63:0] am, bm;
        am = is_32 ? (a & 64'h0000_0000_FFFF_FFFF) : a;
        bm = is_32 ? (b & 64'h0000_0000_FFFF_FFFF) : b;
        if (bm == 64'd0) return is_mod ? am : 64'd0;
`ifdef EBPF_DIV_SIGNED_EN
        if (sgn) begin
            if (is_32) begin
                int sa, sb, q, r;
                logic [31:0] res32;
                sa = am[31:0];
                sb = bm[31:0];
                if (sa == 32'sh8000_0000 && sb == -1) begin q = sa; r = 0; end
                else begin q = sa / sb; r = sa % sb; end
                res32 = is_mod ? r : q;
                return {32'd0, res32};
            end else begin
                longint sa, sb, q, r;
                sa = am;
                sb = bm;
                if (sa == 64'sh8000_0000_0000_0000 && sb == -1) begin q = sa; r = 0; end
                else begin q = sa / sb; r = sa % sb; end
                return is_mod ? r : q;
            end
        end
`endif
        return is_mod ? (am % bm) : (am / bm);
    endfunction

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic is_mod, input logic is_32, input logic sgn, input int hold);
        int lat, guard, exp_lat;
        logic [63:0] exp_y, bm, y0;
        bm      = is_32 ? (b & 64'h0000_0000_FFFF_FFFF) : b;
        exp_y   = ref_y(a, b, is_mod, is_32, sgn);
        exp_lat = (bm == 64'd0) ? 1 : (is_32 ? 33 : 65);

        guard = 0;
        while (!ifc.req_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        check({tag, " req_ready before"}, 64'(ifc.req_ready), 64'd1);

        ifc.req_a         = a;
        ifc.req_b         = b;
        ifc.req_is_mod    = is_mod;
        ifc.req_is_32     = is_32;
        ifc.req_is_signed = sgn;
        ifc.req_valid     = 1'b1;
        ifc.rsp_ready     = (hold == 0);
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        ifc.req_a     = {$urandom, $urandom};
        ifc.req_b     = {$urandom, $urandom};
        ifc.req_is_mod = ~is_mod;

        lat = 1;
        while (!ifc.rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " rsp_y"}, ifc.rsp_y, exp_y);
        y0 = ifc.rsp_y;

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " held rsp_y"}, ifc.rsp_y, y0);
            check({tag, " held rsp_valid"}, 64'(ifc.rsp_valid), 64'd1);
            check({tag, " held req_ready"}, 64'(ifc.req_ready), 64'd0);
        end
        ifc.rsp_ready = 1'b1;
        @(posedge clk); #1;
        ifc.rsp_ready = 1'b0;
        check({tag, " req_ready after"}, 64'(ifc.req_ready), 64'd1);
        check({tag, " rsp_valid after"}, 64'(ifc.rsp_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        ifc.req_valid     = 1'b0;
        ifc.req_a         = '0;
        ifc.req_b         = '0;
        ifc.req_is_mod    = 1'b0;
        ifc.req_is_32     = 1'b0;
        ifc.req_is_signed = 1'b0;
        ifc.rsp_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", 64'(ifc.req_ready), 64'd1);
        check("reset rsp_valid", 64'(ifc.rsp_valid), 64'd0);
        check("reset rsp_y", ifc.rsp_y, 64'd0);
        check("reset busy", 64'(ifc.busy), 64'd0);
        rst = 1'b0;

        run_op("div64", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 0);
        run_op("mod64", 64'd100, 64'd7, 1'b1, 1'b0, 1'b0, 0);
        run_op("div32", 64'hFFFF_FFFF_0000_0064, 64'h1_0000_000A, 1'b0, 1'b1, 1'b0, 0);
        run_op("div0", 64'd5, 64'd0, 1'b0, 1'b0, 1'b0, 0);
        run_op("mod0", 64'd5, 64'd0, 1'b1, 1'b0, 1'b0, 0);
        run_op("mod0_32", 64'h1_0000_0005, 64'h1_0000_0000, 1'b1, 1'b1, 1'b0, 0);
        run_op("backpressure", 64'hDEAD_BEEF_1234_5678, 64'd12345, 1'b0, 1'b0, 1'b0, 10);
        run_op("max64", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
        run_op("bigdiv64", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 1'b0, 0);

        // abandon an operation mid-RUN with the counter at 20
        ifc.req_a     = 64'd1000;
        ifc.req_b     = 64'd3;
        ifc.req_is_mod = 1'b0;
        ifc.req_is_32 = 1'b0;
        ifc.req_is_signed = 1'b0;
        ifc.rsp_ready = 1'b1;
        ifc.req_valid = 1'b1;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrun busy", 64'(ifc.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst req_ready", 64'(ifc.req_ready), 64'd1);
        check("rst rsp_valid", 64'(ifc.rsp_valid), 64'd0);
        check("rst busy", 64'(ifc.busy), 64'd0);
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            check("rst no stale rsp", 64'(ifc.rsp_valid), 64'd0);
        end
        ifc.rsp_ready = 1'b0;
        run_op("after_rst", 64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 0);

`ifdef EBPF_DIV_SIGNED_EN
        run_op("sdiv64", -64'sd7, 64'sd2, 1'b0, 1'b0, 1'b1, 0);
        run_op("smod64", -64'sd7, 64'sd2, 1'b1, 1'b0, 1'b1, 0);
        run_op("sdiv_min", 64'h8000_0000_0000_0000, -64'sd1, 1'b0, 1'b0, 1'b1, 0);
        run_op("smod_min", 64'h8000_0000_0000_0000, -64'sd1, 1'b1, 1'b0, 1'b1, 0);
        run_op("sdiv32", 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 1'b1, 0);
`endif

        for (int k = 0; k < 40; k++) begin
            logic [63:0] a, b;
            int sel;
            a   = {$urandom, $urandom};
            sel = $urandom_range(0, 4);
            case (sel)
                0:       b = {$urandom, 32'd0};
                1:       b = 64'($urandom_range(1, 20));
                2:       b = {32'd0, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            run_op("random", a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
